// File: rtl/mcash_ch_resp_buffer.sv
// rtl/mcash_ch_resp_buffer.sv - channel response FIFO with outstanding-request credit tracking
//
// Buffers responses returning from the cross bar in strict order and presents
// them to the channel master over a valid/allowIn handshake. An outstanding
// request counter issues a credit so the FIFO is never asked to hold more
// responses than it has entries.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mcash_ch_req_fire_i        channel request accepted this cycle
//   req_credit_o               another channel request may be accepted
//   xbar_resp_*_i / allowIn_o  upstream response handshake and payload
//   mcash_ch_resp_*_o / allowIn_i  head response to the channel master
//   outstanding_o              registered outstanding request count
//   err_o                      sticky protocol-error flag
module mcash_ch_resp_buffer #(
   parameter int DEPTH  = 4,
   parameter int OP_W   = 3,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mcash_ch_req_fire_i,
   output logic                         req_credit_o,
   input  logic                         xbar_resp_valid_i,
   output logic                         xbar_resp_allowIn_o,
   input  logic [OP_W-1:0]              xbar_resp_op_i,
   input  logic [ADDR_W-1:0]            xbar_resp_addr_i,
   input  logic [DATA_W-1:0]            xbar_resp_data_i,
   output logic                         mcash_ch_resp_valid_o,
   input  logic                         mcash_ch_resp_allowIn_i,
   output logic [OP_W-1:0]              mcash_ch_resp_op_o,
   output logic [ADDR_W-1:0]            mcash_ch_resp_addr_o,
   output logic [DATA_W-1:0]            mcash_ch_resp_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
   output logic                         err_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = OP_W + ADDR_W + DATA_W;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             err_q, err_d;

   logic             empty, full;
   logic             resp_push, resp_pop;
   logic [ENT_W-1:0] head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

   // No bypass when full: a pop in the same cycle does not open the input.
   assign xbar_resp_allowIn_o   = !full;
   assign mcash_ch_resp_valid_o = !empty;
   assign req_credit_o          = (out_cnt_q != CNT_MAX);
   assign outstanding_o         = out_cnt_q;
   assign err_o                 = err_q;

   assign resp_push = xbar_resp_valid_i & !full;
   assign resp_pop  = !empty & mcash_ch_resp_allowIn_i;

   // Head payload straight from storage; stale when empty, qualified by valid.
   assign head                 = mem_q[rd_ptr_q[IDX_W-1:0]];
   assign mcash_ch_resp_op_o   = head[ENT_W-1 -: OP_W];
   assign mcash_ch_resp_addr_o = head[DATA_W +: ADDR_W];
   assign mcash_ch_resp_data_o = head[DATA_W-1:0];

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      out_cnt_d = out_cnt_q;
      err_d     = err_q;

      if (resp_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (resp_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      // Request fire and response pop cancel out; otherwise saturate at the bounds.
      if (mcash_ch_req_fire_i && !resp_pop) begin
         if (out_cnt_q != CNT_MAX) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
         end
      end else if (resp_pop && !mcash_ch_req_fire_i) begin
         if (out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
         end
      end

      if (mcash_ch_req_fire_i && (out_cnt_q == CNT_MAX)) begin
         err_d = 1'b1;
      end
      if (resp_pop && !mcash_ch_req_fire_i && (out_cnt_q == '0)) begin
         err_d = 1'b1;
      end
      if (resp_push && (out_cnt_q == '0)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         out_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         out_cnt_q <= out_cnt_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (resp_push) begin
         mem_q[wr_ptr_q[IDX_W-1:0]] <= {xbar_resp_op_i, xbar_resp_addr_i, xbar_resp_data_i};
      end
   end

endmodule

// File: tb/tb_mcash_ch_resp_buffer.sv
// tb/tb_mcash_ch_resp_buffer.sv - randomized self-checking bench for mcash_ch_resp_buffer
module tb_mcash_ch_resp_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_fire = 1'b0;
   logic        req_credit;
   logic        x_valid = 1'b0;
   logic        x_allow;
   logic [2:0]  x_op = '0;
   logic [31:0] x_addr = '0;
   logic [63:0] x_data = '0;
   logic        r_valid;
   logic        r_allow = 1'b0;
   logic [2:0]  r_op;
   logic [31:0] r_addr;
   logic [63:0] r_data;
   logic [2:0]  outstanding;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [63:0] data;
   } ent_t;

   ent_t m_q[$];
   int   m_cnt = 0;
   bit   m_err = 0;

   always #5 clk = ~clk;

   mcash_ch_resp_buffer #(.DEPTH(DEPTH), .OP_W(3), .ADDR_W(32), .DATA_W(64)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .mcash_ch_req_fire_i     (req_fire),
      .req_credit_o            (req_credit),
      .xbar_resp_valid_i       (x_valid),
      .xbar_resp_allowIn_o     (x_allow),
      .xbar_resp_op_i          (x_op),
      .xbar_resp_addr_i        (x_addr),
      .xbar_resp_data_i        (x_data),
      .mcash_ch_resp_valid_o   (r_valid),
      .mcash_ch_resp_allowIn_i (r_allow),
      .mcash_ch_resp_op_o      (r_op),
      .mcash_ch_resp_addr_o    (r_addr),
      .mcash_ch_resp_data_o    (r_data),
      .outstanding_o           (outstanding),
      .err_o                   (err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("resp_valid", 64'(r_valid), 64'(m_q.size() != 0));
      chk("allowIn", 64'(x_allow), 64'(m_q.size() != DEPTH));
      chk("credit", 64'(req_credit), 64'(m_cnt != DEPTH));
      chk("outstanding", 64'(outstanding), 64'(m_cnt));
      chk("err", 64'(err), 64'(m_err));
      if (m_q.size() != 0) begin
         chk("head_op", 64'(r_op), 64'(m_q[0].op));
         chk("head_addr", 64'(r_addr), 64'(m_q[0].addr));
         chk("head_data", r_data, m_q[0].data);
      end
   endtask

   // Called at a falling edge: check, drive, let one rising edge pass, update model.
   task automatic step(input bit fire, input bit vld, input bit allow,
                       input logic [2:0] op, input logic [31:0] addr, input logic [63:0] data);
      bit   push, pop;
      ent_t e;
      check_outputs();
      req_fire = fire;
      x_valid  = vld;
      r_allow  = allow;
      x_op     = op;
      x_addr   = addr;
      x_data   = data;
      push = vld && (m_q.size() < DEPTH);
      pop  = allow && (m_q.size() > 0);
      if (fire && m_cnt == DEPTH) m_err = 1;
      if (pop && !fire && m_cnt == 0) m_err = 1;
      if (push && m_cnt == 0) m_err = 1;
      @(posedge clk);
      if (fire && !pop) m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
      else if (pop && !fire) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         e.op = op; e.addr = addr; e.data = data;
         m_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit allow);
      step(0, 0, allow, 3'd0, 32'd0, 64'd0);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cnt = 0;
      m_err = 0;
   endtask

   // Reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", 64'(r_valid), 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_allowIn", 64'(x_allow), 64'd1);
      chk("rst_credit", 64'(req_credit), 64'd1);
      chk("rst_err", 64'(err), 64'd0);
      req_fire = 0; x_valid = 0; r_allow = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_op", 64'(r_op), 64'd0);
      chk("reset_addr", 64'(r_addr), 64'd0);
      chk("reset_data", r_data, 64'd0);
      repeat (3) idle(0);

      // Four requests, four responses held back, then drained in order.
      repeat (4) step(1, 0, 0, 3'd0, 32'd0, 64'd0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 3'(i + 1), 32'h100 + 32'(8 * i), 64'hA0 + 64'(i));
      chk("full_outstanding", 64'(outstanding), 64'd4);
      chk("full_credit", 64'(req_credit), 64'd0);
      chk("full_allowIn", 64'(x_allow), 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_addr", 64'(r_addr), 64'h100 + 64'(8 * i));
         step(0, 0, 1, 3'd0, 32'd0, 64'd0);
         chk("drain_outstanding", 64'(outstanding), 64'(3 - i));
      end

      // Streaming: one push and one pop per cycle, pointers wrap several times.
      step(1, 0, 1, 3'd0, 32'd0, 64'd0);
      step(0, 1, 1, 3'd5, 32'h4000, 64'h5000);
      for (int i = 1; i < 20; i++) step(1, 1, 1, 3'(i), 32'h4000 + 32'(i), 64'h5000 + 64'(i));
      step(0, 0, 1, 3'd0, 32'd0, 64'd0);
      chk("stream_err", 64'(err), 64'd0);

      // Full with simultaneous pop and push: the push is refused.
      repeat (4) step(1, 0, 0, 3'd0, 32'd0, 64'd0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 3'd2, 32'h200 + 32'(i), 64'hB0 + 64'(i));
      chk("fullpp_allowIn", 64'(x_allow), 64'd0);
      step(0, 1, 1, 3'd7, 32'hDEAD, 64'hDEAD);
      chk("fullpp_allowIn_next", 64'(x_allow), 64'd1);
      repeat (4) idle(1);

      // Push with nothing outstanding, then pop it.
      step(0, 1, 0, 3'd1, 32'h300, 64'hC0);
      chk("err_push", 64'(err), 64'd1);
      idle(1);
      chk("err_pop_cnt", 64'(outstanding), 64'd0);
      repeat (2) idle(0);
      chk("err_sticky", 64'(err), 64'd1);

      async_reset();
      repeat (5) step(1, 0, 0, 3'd0, 32'd0, 64'd0);
      chk("err_fire5", 64'(err), 64'd1);
      chk("fire5_outstanding", 64'(outstanding), 64'd4);

      // Three buffered entries wiped by a mid-stream reset.
      async_reset();
      repeat (3) step(1, 0, 0, 3'd0, 32'd0, 64'd0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 3'd3, 32'h600 + 32'(i), 64'hE0 + 64'(i));
      async_reset();
      step(1, 0, 0, 3'd0, 32'd0, 64'd0);
      step(0, 1, 0, 3'd6, 32'h2000, 64'h1234_5678);
      chk("post_rst_data", r_data, 64'h1234_5678);
      idle(1);

      // Protocol-legal random traffic.
      for (int i = 0; i < 300; i++) begin
         bit f, v;
         f = (m_cnt < DEPTH) && ($urandom_range(0, 2) != 0);
         v = (m_cnt > m_q.size()) && ($urandom_range(0, 2) != 0);
         step(f, v, $urandom_range(0, 1) == 1, 3'($urandom), $urandom, {$urandom, $urandom});
      end
      chk("legal_err", 64'(err), 64'd0);

      // Unconstrained random traffic, including protocol errors.
      async_reset();
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              3'($urandom), $urandom, {$urandom, $urandom});
      end
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
